// File: rtl/cap_mem_pkg.sv
// cap_mem_pkg: shared types and constants for the capture SRAM controller.
//   cap_state_t     - capture FSM state encoding (IDLE / CAPTURE / DONE)
//   DEF_ADDR_WIDTH  - default SRAM address width (32768 words)
//   DEF_DATA_WIDTH  - default SRAM word width
//   RD_LATENCY      - cycles from read issue to read data on mem_q
package cap_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_DATA_WIDTH = 36;
    localparam int RD_LATENCY     = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/cap_mem_arb.sv
// cap_mem_arb: single SRAM port arbitration between the capture writer and
// the readout requester, plus the read-valid pipe and read-data hold.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   wr_en              - capture write this cycle (already qualified by FSM)
//   wr_addr, wr_data   - capture write address / data
//   rd_req, rd_addr    - readout request / address
//   mem_q              - SRAM read data (RD_LATENCY after issue)
//   rd_gnt             - read issued to SRAM this cycle
//   rd_vld, rd_data    - returned read data and its valid
//   mem_ceb, mem_web   - SRAM chip / write enable, active low
//   mem_a, mem_d       - SRAM address / write data (hold when idle)
module cap_mem_arb
    import cap_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_ceb,
    output logic                  mem_web,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_d
);

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [ADDR_WIDTH-1:0] a_hold;
    logic [DATA_WIDTH-1:0] d_hold;
    logic [DATA_WIDTH-1:0] q_hold;

    // Writes win; no SRAM access is started while reset is asserted so the
    // macro sees a quiet port during the reset cycle.
    assign rd_gnt = rd_req & ~wr_en & rst_n;

    always_comb begin
        mem_ceb = 1'b1;
        mem_web = 1'b1;
        mem_a   = a_hold;
        mem_d   = d_hold;
        if (wr_en && rst_n) begin
            mem_ceb = 1'b0;
            mem_web = 1'b0;
            mem_a   = wr_addr;
            mem_d   = wr_data;
        end else if (rd_gnt) begin
            mem_ceb = 1'b0;
            mem_a   = rd_addr;
        end
    end

    assign rd_vld  = vld_pipe[RD_LATENCY-1];
    // mem_q is only meaningful in the valid cycle; otherwise show the last
    // returned word.
    assign rd_data = rd_vld ? mem_q : q_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            a_hold   <= '0;
            d_hold   <= '0;
            q_hold   <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(rd_gnt);
            if (!mem_ceb) a_hold <= mem_a;
            if (!mem_web) d_hold <= mem_d;
            if (rd_vld)   q_hold <= mem_q;
        end
    end

endmodule

// File: rtl/cap_mem_ctrl.sv
// cap_mem_ctrl: capture sequencer for the single-port capture SRAM.
// Streams capture words into incrementing addresses and shares the SRAM
// port with a readout requester (writes have priority).
// Build option: CAP_MEM_RING_EN - continuous ring capture with cap_stop,
//   wrapped and last_ptr ports; otherwise length-terminated capture only.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   cap_start, cap_len         - start pulse and word count (0 = ignored)
//   wr_valid, wr_data, wr_ready- capture word stream
//   cap_busy, cap_done, wr_cnt - capture status
//   rd_req, rd_addr, rd_gnt    - readout request / grant
//   rd_vld, rd_data            - readout return
//   mem_ceb, mem_web, mem_a, mem_d, mem_q - SRAM wrapper pins
//
// state     | meaning
// ST_IDLE   | no capture since reset
// ST_CAPTURE| accepting capture words, wr_ready high
// ST_DONE   | capture finished, results held until next cap_start
module cap_mem_ctrl
    import cap_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_start,
    input  logic [ADDR_WIDTH:0]   cap_len,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  cap_busy,
    output logic                  cap_done,
    output logic [ADDR_WIDTH:0]   wr_cnt,
`ifdef CAP_MEM_RING_EN
    input  logic                  cap_stop,
    output logic                  wrapped,
    output logic [ADDR_WIDTH-1:0] last_ptr,
`endif
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_ceb,
    output logic                  mem_web,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    cap_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   wr_cnt_inc;
    logic                  start_ok;
    logic                  wr_en;
`ifndef CAP_MEM_RING_EN
    logic [ADDR_WIDTH:0]   len_q;
`endif

    assign start_ok   = cap_start & (cap_len != '0) & (state != ST_CAPTURE);
    assign wr_en      = (state == ST_CAPTURE) & wr_valid;
    assign wr_cnt_inc = wr_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap_busy  = 1'b0;
        cap_done  = 1'b0;
        wr_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                cap_busy = 1'b1;
                wr_ready = 1'b1;
`ifdef CAP_MEM_RING_EN
                if (cap_stop) state_nxt = ST_DONE;
`else
                if (wr_en && (wr_cnt_inc == len_q)) state_nxt = ST_DONE;
`endif
            end
            ST_DONE: begin
                cap_done = 1'b1;
                if (start_ok) state_nxt = ST_CAPTURE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            wr_cnt   <= '0;
`ifdef CAP_MEM_RING_EN
            wrapped  <= 1'b0;
            last_ptr <= '0;
`else
            len_q    <= '0;
`endif
        end else if (start_ok) begin
            wr_ptr   <= '0;
            wr_cnt   <= '0;
`ifdef CAP_MEM_RING_EN
            wrapped  <= 1'b0;
`else
            len_q    <= (cap_len > DEPTH) ? DEPTH : cap_len;
`endif
        end else if (wr_en) begin
            // Pointer wraps naturally modulo depth.
            wr_ptr <= wr_ptr + 1'b1;
`ifdef CAP_MEM_RING_EN
            if (wr_cnt != DEPTH) wr_cnt <= wr_cnt_inc;
            if (&wr_ptr)         wrapped <= 1'b1;
            last_ptr <= wr_ptr;
`else
            wr_cnt <= wr_cnt_inc;
`endif
        end
    end

    cap_mem_arb #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .mem_q   (mem_q),
        .rd_gnt  (rd_gnt),
        .rd_vld  (rd_vld),
        .rd_data (rd_data),
        .mem_ceb (mem_ceb),
        .mem_web (mem_web),
        .mem_a   (mem_a),
        .mem_d   (mem_d)
    );

endmodule

// File: tb/tb_cap_mem_ctrl.sv
// tb_cap_mem_ctrl: directed bench for cap_mem_ctrl with a behavioural
// single-port SRAM (write or read per cycle, 1-cycle read latency).
module tb_cap_mem_ctrl;

    localparam int AW = 15;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cap_start;
    logic [AW:0]   cap_len;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          cap_busy;
    logic          cap_done;
    logic [AW:0]   wr_cnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          mem_ceb;
    logic          mem_web;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q = '0;
`ifdef CAP_MEM_RING_EN
    logic          cap_stop = 1'b0;
    logic          wrapped;
    logic [AW-1:0] last_ptr;
`endif

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cap_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cap_start(cap_start), .cap_len(cap_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .cap_busy(cap_busy), .cap_done(cap_done), .wr_cnt(wr_cnt),
`ifdef CAP_MEM_RING_EN
        .cap_stop(cap_stop), .wrapped(wrapped), .last_ptr(last_ptr),
`endif
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_vld(rd_vld), .rd_data(rd_data),
        .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_a(mem_a), .mem_d(mem_d),
        .mem_q(mem_q)
    );

    always @(posedge clk) begin
        if (!mem_ceb) begin
            if (!mem_web) ram[mem_a] <= mem_d;
            else          mem_q      <= ram[mem_a];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cap_start = 1'b0; cap_len = '0; wr_valid = 1'b0;
        wr_data = '0; rd_req = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", cap_busy, 0);
        chk("rst_done", cap_done, 0);
        chk("rst_cnt",  wr_cnt, 0);
        chk("rst_vld",  rd_vld, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_ceb",  mem_ceb, 1);
        chk("rst_web",  mem_web, 1);
        chk("rst_ready", wr_ready, 0);
        rst_n = 1'b1;

        // four-word capture
        cap_start = 1'b1; cap_len = 4;
        step();
        cap_start = 1'b0;
        #1;
        chk("cap4_busy", cap_busy, 1);
        chk("cap4_done0", cap_done, 0);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = DW'(i + 1);
            #1;
            chk("cap4_ready", wr_ready, 1);
            chk("cap4_ceb", mem_ceb, 0);
            chk("cap4_web", mem_web, 0);
            chk("cap4_a", mem_a, i);
            chk("cap4_d", mem_d, i + 1);
            step();
        end
        wr_data = 36'hBAD;
        #1;
        chk("cap4_done", cap_done, 1);
        chk("cap4_idle", cap_busy, 0);
        chk("cap4_cnt", wr_cnt, 4);
        chk("cap4_ready0", wr_ready, 0);
        chk("cap4_drop_ceb", mem_ceb, 1);
        chk("cap4_hold_a", mem_a, 3);
        wr_valid = 1'b0;

        // single read
        rd_req = 1'b1; rd_addr = 2;
        #1;
        chk("rd_gnt", rd_gnt, 1);
        chk("rd_ceb", mem_ceb, 0);
        chk("rd_web", mem_web, 1);
        chk("rd_a", mem_a, 2);
        step();
        rd_req = 1'b0;
        #1;
        chk("rd_vld", rd_vld, 1);
        chk("rd_data", rd_data, 3);
        step();
        chk("rd_vld_off", rd_vld, 0);
        chk("rd_data_hold", rd_data, 3);

        // back-to-back reads
        rd_req = 1'b1; rd_addr = 0;
        #1;
        chk("b2b_gnt0", rd_gnt, 1);
        step();
        rd_addr = 3;
        #1;
        chk("b2b_gnt1", rd_gnt, 1);
        chk("b2b_vld0", rd_vld, 1);
        chk("b2b_data0", rd_data, 1);
        step();
        rd_req = 1'b0;
        #1;
        chk("b2b_vld1", rd_vld, 1);
        chk("b2b_data1", rd_data, 4);
        step();
        chk("b2b_vld_off", rd_vld, 0);

        // eight-word capture with a competing read
        cap_start = 1'b1; cap_len = 8;
        step();
        cap_start = 1'b0;
        #1;
        chk("cap8_busy", cap_busy, 1);
        chk("cap8_done0", cap_done, 0);
        chk("cap8_cnt0", wr_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = DW'(16 + i); rd_req = 1'b1; rd_addr = 1;
            #1;
            chk("arb_gnt_blocked", rd_gnt, 0);
            chk("arb_web_wr", mem_web, 0);
            chk("arb_a_wr", mem_a, i);
            step();
            chk("arb_vld_none", rd_vld, 0);
        end
        wr_valid = 1'b0;
        #1;
        chk("arb_gnt", rd_gnt, 1);
        chk("arb_a_rd", mem_a, 1);
        chk("arb_web_rd", mem_web, 1);
        step();
        rd_req = 1'b0;
        #1;
        chk("arb_vld", rd_vld, 1);
        chk("arb_data", rd_data, 17);
        chk("arb_cnt", wr_cnt, 3);
        for (int i = 3; i < 8; i++) begin
            wr_valid = 1'b1; wr_data = DW'(16 + i);
            step();
        end
        wr_valid = 1'b0;
        #1;
        chk("cap8_done", cap_done, 1);
        chk("cap8_cnt", wr_cnt, 8);

        // reset in the middle of a capture
        cap_start = 1'b1; cap_len = 20;
        step();
        cap_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_data = DW'(256 + i);
            step();
        end
        wr_valid = 1'b0;
        #1;
        chk("mid_cnt", wr_cnt, 10);
        chk("mid_busy", cap_busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("mrst_busy", cap_busy, 0);
        chk("mrst_done", cap_done, 0);
        chk("mrst_cnt", wr_cnt, 0);
        chk("mrst_ceb", mem_ceb, 1);
        chk("mrst_vld", rd_vld, 0);

        // zero length start is ignored
        cap_start = 1'b1; cap_len = 0;
        step();
        cap_start = 1'b0;
        #1;
        chk("len0_busy", cap_busy, 0);
        chk("len0_done", cap_done, 0);
        chk("len0_ready", wr_ready, 0);

        // oversize length clamps to full depth; a start mid-capture is ignored
        cap_start = 1'b1; cap_len = 40000;
        step();
        cap_start = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            wr_valid = 1'b1; wr_data = DW'(i);
            cap_start = (i == 100); cap_len = 4;
            if (i == (1 << AW) - 1) begin
                #1;
                chk("clamp_last_a", mem_a, 15'h7FFF);
                chk("clamp_cnt_pre", wr_cnt, 32767);
                chk("clamp_busy", cap_busy, 1);
            end
            step();
        end
        wr_valid = 1'b0; cap_start = 1'b0;
        #1;
        chk("clamp_done", cap_done, 1);
        chk("clamp_cnt", wr_cnt, 32768);
        rd_req = 1'b1; rd_addr = 15'h7FFF;
        step();
        rd_addr = 100;
        #1;
        chk("clamp_rd_top", rd_data, 32767);
        step();
        rd_req = 1'b0;
        #1;
        chk("clamp_rd_100", rd_data, 100);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
